// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths, JAL opcode and J-immediate decode for the fetch front end
package inst_fetch_queue_pkg;

    localparam int PcLength   = 32;
    localparam int DataLength = 32;

    localparam logic [6:0] JalOpcode = 7'b1101111;

    // Sign-extended J-type immediate: imm[20|10:1|11|19:12] lives in instr[31:12].
    function automatic logic [PcLength-1:0] j_imm(input logic [DataLength-1:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_queue_fetch_pc_fifo.sv
// rtl/inst_fetch_queue_fetch_pc_fifo.sv - small FIFO of issued fetch PCs, head shown combinationally
module fetch_pc_fifo #(
    parameter int Depth = 3,
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout
);

    localparam int IdxW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem [Depth];
    logic [IdxW-1:0]  wr_q;
    logic [IdxW-1:0]  rd_q;

    // Depth need not be a power of two, so indices wrap explicitly.
    function automatic logic [IdxW-1:0] bump(input logic [IdxW-1:0] i);
        return (int'(i) == Depth - 1) ? '0 : i + IdxW'(1);
    endfunction

    assign dout = mem[rd_q];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) begin
                wr_q <= bump(wr_q);
            end
            if (pop) begin
                rd_q <= bump(rd_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !flush && push) begin
            mem[wr_q] <= din;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - sequential fetch issue, in-order instruction queue, ROB flush; JAL_PREDICT_EN adds JAL redirect
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int QueueDepthLog = 3,
    parameter int MaxInflight   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  is_ready_from_fc,
    input  logic                  is_commit_from_fc,
    input  logic                  is_instr_from_fc,
    input  logic [DataLength-1:0] data_from_fc,
    input  logic                  is_exception_from_rob,
    input  logic [PcLength-1:0]   pc_from_rob,
    input  logic                  is_pop_from_dc,
    output logic                  is_empty_to_fc,
    output logic [PcLength-1:0]   addr_to_fc,
    output logic                  is_empty_to_dc,
    output logic [DataLength-1:0] instr_to_dc,
    output logic [PcLength-1:0]   pc_to_dc
);

    localparam int Depth = 1 << QueueDepthLog;
    localparam int PtrW  = QueueDepthLog + 1;
    localparam int CntW  = $clog2(MaxInflight + 1);

    logic [PcLength-1:0]   pc_q;
    logic [CntW-1:0]       inflight_q;
    logic [CntW-1:0]       discard_q;
    logic [PtrW-1:0]       wr_ptr_q;
    logic [PtrW-1:0]       rd_ptr_q;
    logic [DataLength-1:0] q_data [Depth];
    logic [PcLength-1:0]   q_pc   [Depth];

    logic [PtrW-1:0]          count;
    logic [PtrW-1:0]          rd_next;
    logic                     q_empty;
    logic                     q_full;
    logic                     ret_valid;
    logic                     push;
    logic                     pop;
    logic                     issue;
    logic                     redirect;
    logic [PcLength-1:0]      redirect_pc;
    logic [PcLength-1:0]      ret_pc;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign rd_next = rd_ptr_q + PtrW'(1);
    assign q_empty = (wr_ptr_q == rd_ptr_q);
    assign q_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);

    assign is_empty_to_dc = q_empty;

    // Returns with nothing outstanding cannot belong to us and are ignored.
    assign ret_valid = is_commit_from_fc && is_instr_from_fc && (inflight_q != '0) && !is_exception_from_rob;
    assign push      = ret_valid && (discard_q == '0) && !q_full;
    assign pop       = is_pop_from_dc && !q_empty && !is_exception_from_rob;

`ifdef JAL_PREDICT_EN
    assign redirect    = push && (data_from_fc[6:0] == JalOpcode);
    assign redirect_pc = ret_pc + j_imm(data_from_fc);
`else
    assign redirect    = 1'b0;
    assign redirect_pc = pc_q;
`endif

    // Slots are reserved at issue time so a returning word always finds room.
    assign issue = is_ready_from_fc && !is_exception_from_rob && !redirect &&
                   (int'(inflight_q) < MaxInflight) &&
                   (int'(count) + int'(inflight_q) < Depth);

    fetch_pc_fifo #(
        .Depth (MaxInflight),
        .Width (PcLength)
    ) u_pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rdy && issue),
        .pop   (rdy && ret_valid && (discard_q == '0)),
        .flush (rdy && (is_exception_from_rob || redirect)),
        .din   (pc_q),
        .dout  (ret_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q           <= '0;
            inflight_q     <= '0;
            discard_q      <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            is_empty_to_fc <= 1'b1;
            addr_to_fc     <= '0;
            instr_to_dc    <= '0;
            pc_to_dc       <= '0;
        end else if (rdy) begin
            if (is_exception_from_rob) begin
                pc_q           <= pc_from_rob;
                inflight_q     <= '0;
                discard_q      <= '0;
                wr_ptr_q       <= '0;
                rd_ptr_q       <= '0;
                is_empty_to_fc <= 1'b1;
                instr_to_dc    <= '0;
                pc_to_dc       <= '0;
            end else begin
                is_empty_to_fc <= !issue;
                if (issue) begin
                    addr_to_fc <= pc_q;
                end
                if (redirect) begin
                    pc_q <= redirect_pc;
                end else if (issue) begin
                    pc_q <= pc_q + PcLength'(4);
                end
                inflight_q <= inflight_q + CntW'(issue) - CntW'(ret_valid);
                // A redirecting return never issues, so everything still out is stale.
                if (redirect) begin
                    discard_q <= inflight_q - CntW'(1);
                end else if (ret_valid && (discard_q != '0)) begin
                    discard_q <= discard_q - CntW'(1);
                end
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_next;
                end
                // Keep the registered head in step with the queue.
                if (pop) begin
                    if (count > PtrW'(1)) begin
                        instr_to_dc <= q_data[rd_next[QueueDepthLog-1:0]];
                        pc_to_dc    <= q_pc[rd_next[QueueDepthLog-1:0]];
                    end else if (push) begin
                        instr_to_dc <= data_from_fc;
                        pc_to_dc    <= ret_pc;
                    end
                end else if (push && q_empty) begin
                    instr_to_dc <= data_from_fc;
                    pc_to_dc    <= ret_pc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && rdy && push) begin
            q_data[wr_ptr_q[QueueDepthLog-1:0]] <= data_from_fc;
            q_pc[wr_ptr_q[QueueDepthLog-1:0]]   <= ret_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed and randomized bench for inst_fetch_queue against a queue-level model
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;
    localparam int MAXI  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        is_ready_from_fc;
    logic        is_commit_from_fc;
    logic        is_instr_from_fc;
    logic [31:0] data_from_fc;
    logic        is_exception_from_rob;
    logic [31:0] pc_from_rob;
    logic        is_pop_from_dc;
    logic        is_empty_to_fc;
    logic [31:0] addr_to_fc;
    logic        is_empty_to_dc;
    logic [31:0] instr_to_dc;
    logic [31:0] pc_to_dc;

    inst_fetch_queue dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .is_ready_from_fc      (is_ready_from_fc),
        .is_commit_from_fc     (is_commit_from_fc),
        .is_instr_from_fc      (is_instr_from_fc),
        .data_from_fc          (data_from_fc),
        .is_exception_from_rob (is_exception_from_rob),
        .pc_from_rob           (pc_from_rob),
        .is_pop_from_dc        (is_pop_from_dc),
        .is_empty_to_fc        (is_empty_to_fc),
        .addr_to_fc            (addr_to_fc),
        .is_empty_to_dc        (is_empty_to_dc),
        .instr_to_dc           (instr_to_dc),
        .pc_to_dc              (pc_to_dc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [31:0] p;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] pcq[$];
    logic [31:0] m_pc;
    int          m_inflight;
    int          m_discard;
    bit          m_req_valid;
    logic [31:0] m_req_addr;
    bit          m_reset_vals;

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef JAL_PREDICT_EN
    function automatic logic [31:0] jimm(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction
`endif

    // Advances the model across the coming posedge using the inputs now driven.
    task automatic model_step();
        ent_t        e;
        logic [31:0] rpc;
        logic [31:0] tgt;
        bit          redirect;
        int          cnt0;
        int          inf0;
        if (!rst) begin
            mq.delete();
            pcq.delete();
            m_pc = 0; m_inflight = 0; m_discard = 0;
            m_req_valid = 0; m_req_addr = 0; m_reset_vals = 1;
            return;
        end
        if (!rdy) return;
        m_reset_vals = 0;
        if (is_exception_from_rob) begin
            mq.delete();
            pcq.delete();
            m_pc = pc_from_rob; m_inflight = 0; m_discard = 0; m_req_valid = 0;
            return;
        end
        cnt0 = mq.size();
        inf0 = m_inflight;
        redirect = 0;
        tgt = 0;
        if (is_pop_from_dc && cnt0 > 0) void'(mq.pop_front());
        if (is_commit_from_fc && is_instr_from_fc && inf0 > 0) begin
            m_inflight--;
            if (m_discard > 0) begin
                m_discard--;
            end else begin
                rpc = pcq.pop_front();
                e.d = data_from_fc;
                e.p = rpc;
                mq.push_back(e);
`ifdef JAL_PREDICT_EN
                if (data_from_fc[6:0] == 7'b1101111) begin
                    redirect = 1;
                    tgt = rpc + jimm(data_from_fc);
                    m_discard = m_inflight;
                    pcq.delete();
                end
`endif
            end
        end
        if (is_ready_from_fc && inf0 < MAXI && cnt0 + inf0 < DEPTH && !redirect) begin
            m_req_valid = 1;
            m_req_addr = m_pc;
            pcq.push_back(m_pc);
            m_pc = m_pc + 32'd4;
            m_inflight++;
        end else begin
            m_req_valid = 0;
        end
        if (redirect) m_pc = tgt;
    endtask

    task automatic compare_all();
        chk("is_empty_to_fc", {31'd0, is_empty_to_fc}, {31'd0, !m_req_valid});
        if (m_req_valid || m_reset_vals) chk("addr_to_fc", addr_to_fc, m_req_addr);
        chk("is_empty_to_dc", {31'd0, is_empty_to_dc}, {31'd0, mq.size() == 0});
        if (mq.size() > 0) begin
            chk("instr_to_dc", instr_to_dc, mq[0].d);
            chk("pc_to_dc", pc_to_dc, mq[0].p);
        end else if (m_reset_vals) begin
            chk("instr_to_dc_rst", instr_to_dc, 32'd0);
            chk("pc_to_dc_rst", pc_to_dc, 32'd0);
        end
    endtask

    task automatic set_in(input logic r, input logic rd, input logic rfc, input logic cm, input logic ins,
                          input logic [31:0] d, input logic ex, input logic [31:0] rpc, input logic pp);
        rst = r; rdy = rd; is_ready_from_fc = rfc; is_commit_from_fc = cm; is_instr_from_fc = ins;
        data_from_fc = d; is_exception_from_rob = ex; pc_from_rob = rpc; is_pop_from_dc = pp;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [31:0] d;
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        tick();
        chk("rst_empty_fc", {31'd0, is_empty_to_fc}, 32'd1);
        chk("rst_addr", addr_to_fc, 32'd0);
        chk("rst_empty_dc", {31'd0, is_empty_to_dc}, 32'd1);
        chk("rst_instr", instr_to_dc, 32'd0);
        chk("rst_pc", pc_to_dc, 32'd0);

        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("first_req_valid", {31'd0, is_empty_to_fc}, 32'd0);
        chk("first_req_addr", addr_to_fc, 32'h0);
        tick();
        chk("second_req_addr", addr_to_fc, 32'h4);
        tick();
        chk("third_req_addr", addr_to_fc, 32'h8);
        tick();
        chk("inflight_limit", {31'd0, is_empty_to_fc}, 32'd1);

        set_in(1, 1, 1, 1, 1, 32'hAAAA0013, 0, 0, 0);
        tick();
        chk("ret1_empty_dc", {31'd0, is_empty_to_dc}, 32'd0);
        chk("ret1_instr", instr_to_dc, 32'hAAAA0013);
        chk("ret1_pc", pc_to_dc, 32'h0);
        set_in(1, 1, 1, 1, 1, 32'hBBBB0013, 0, 0, 1);
        tick();
        chk("ret2_instr", instr_to_dc, 32'hBBBB0013);
        chk("ret2_pc", pc_to_dc, 32'h4);
        chk("ret2_issue", addr_to_fc, 32'hC);

        set_in(1, 1, 0, 1, 1, 32'h11110013, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 1, 0, 1, 1, 32'h22220013, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("pre_exc_addr", addr_to_fc, 32'h14);
        set_in(1, 1, 1, 1, 1, 32'h33330013, 1, 32'h1000, 1);
        tick();
        chk("exc_empty_dc", {31'd0, is_empty_to_dc}, 32'd1);
        chk("exc_no_req", {31'd0, is_empty_to_fc}, 32'd1);
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("exc_restart_valid", {31'd0, is_empty_to_fc}, 32'd0);
        chk("exc_restart_addr", addr_to_fc, 32'h1000);

        for (int i = 0; i < 30; i++) begin
            set_in(1, 1, 1, m_inflight > 0, 1, 32'hC0DE0000 + i, 0, 0, 0);
            tick();
        end
        chk("bp_stalled", {31'd0, is_empty_to_fc}, 32'd1);
        chk("bp_last_addr", addr_to_fc, 32'h101C);
        for (int i = 0; i < 8; i++) begin
            chk("bp_pop_pc", pc_to_dc, 32'h1000 + 32'(4 * i));
            set_in(1, 1, 0, 0, 0, 0, 0, 0, 1);
            tick();
        end
        chk("bp_drained", {31'd0, is_empty_to_dc}, 32'd1);

        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            set_in(1, 1, 1, m_inflight > 0, 1, 32'h5A5A0000 + i, 0, 0, 1'(i & 1));
            tick();
        end

`ifdef JAL_PREDICT_EN
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick(); tick(); tick();
        set_in(1, 1, 1, 1, 1, 32'h00000013, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 1, 1, 32'h00000013, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 1, 1, 32'h1000006F, 0, 0, 0);
        tick();
        set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("jal_target", addr_to_fc, 32'h108);
        for (int i = 0; i < 6; i++) begin
            set_in(1, 1, 1, m_inflight > 0, 1, 32'h77770013, 0, 0, 0);
            tick();
        end
        chk("jal_pc_after_drop", pc_to_dc, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            d = $urandom;
`ifdef JAL_PREDICT_EN
            if ($urandom_range(0, 7) == 0) d[6:0] = 7'b1101111;
`endif
            set_in($urandom_range(0, 299) != 0,
                   $urandom_range(0, 9) != 0,
                   $urandom_range(0, 3) != 0,
                   (m_inflight > 0) && ($urandom_range(0, 1) == 1),
                   $urandom_range(0, 6) != 0,
                   d,
                   $urandom_range(0, 49) == 0,
                   $urandom & 32'hFFFF_FFFC,
                   $urandom_range(0, 1) == 1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
